// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline accumulator: default sizes and FSM encoding.
package pipe_pkg;

  localparam int N_DEF = 10;
  localparam int K_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Counter width able to hold 0..k-1; never below one bit.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/pipe_acc_if.sv
// Sample-in / result-out handshake bundle between the pipeline and its consumer.
interface pipe_acc_if
  import pipe_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] out_sum;
  logic [N-1:0]   out_max;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_max, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_max, out_valid
  );

endinterface

// File: rtl/pipe_acc_cnt.sv
// Mod-K sample counter; tc flags the increment that completes a block.
module pipe_acc_cnt
  import pipe_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int CW = cnt_width(K)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0] count;

  assign tc = inc && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_acc.sv
// Block accumulator: sums and takes the maximum of K accepted samples, then
// holds the result until the consumer takes it.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | no samples in the current block
//   ACC     | 1..K-1 samples accumulated
//   HOLD    | block complete, result pending on the output
module pipe_acc
  import pipe_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  pipe_acc_if.slave   bus
);

  state_t         state_q;
  state_t         state_d;
  logic           accept;
  logic           handoff;
  logic           tc;
  logic           cnt_clear;
  logic           ready;
  logic           out_valid_q;
  logic [2*N-1:0] sum_q;
  logic [N-1:0]   max_q;
  logic [2*N-1:0] in_ext;

  assign accept    = bus.in_valid && ready;
  assign handoff   = (state_q == ST_HOLD) && bus.out_ready;
  assign cnt_clear = clear || handoff;
  assign in_ext    = {{N{1'b0}}, bus.in_data};

  pipe_acc_cnt #(.K(K)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (accept),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // tc on the first sample means K==1, so the block completes immediately.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept)        state_d = tc ? ST_HOLD : ST_ACC;
        ST_ACC:  if (tc)            state_d = ST_HOLD;
        ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
        default:                    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = 1'b1;
    if (state_q == ST_HOLD) begin
      ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  // Result registers are left untouched on handoff; only reset/clear zero them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        sum_q <= in_ext;
        max_q <= bus.in_data;
      end else begin
        sum_q <= sum_q + in_ext;
        max_q <= (bus.in_data > max_q) ? bus.in_data : max_q;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_max   = max_q;

endmodule
